// File: rtl/img_descpt_feeder_pkg.sv
// Shared types and constants for the image descriptor feeder.
// The pad word is the all-ones keypoint used for the empty lanes of a partial last group.
package img_descpt_feeder_pkg;

    localparam int IMG_RCD_W  = 403;
    localparam int IMG_ADDR_W = 9;
    localparam int IMG_KPT_W  = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READ,
        ST_LAT,
        ST_VALID
    } feed_state_t;

    localparam logic [IMG_RCD_W-1:0] PAD_WORD = '1;

    // A lane is padding when the group is partial and the lane lies past the last real keypoint
    function automatic logic lane_is_pad(input logic [1:0] lane, input logic [1:0] rem);
        return (rem != 2'd0) && (lane >= rem);
    endfunction

endpackage

// File: rtl/img_descpt_feeder_rd_lat_pipe.sv
// Delay line that turns the read-issue strobe into a capture strobe aligned with memory data.
module rd_lat_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (flush) begin
            sr <= '0;
        end else begin
            sr <= DEPTH'({sr, din});
        end
    end

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/img_descpt_feeder.sv
// Responder side of the matcher descriptor handshake: fetches 4-keypoint groups from image memory.
// Optional feature macro IMG_PARTIAL_PAD_EN: round the group count up and pad the partial last group.
module img_descpt_feeder
    import img_descpt_feeder_pkg::*;
#(
    parameter int RCD_W  = IMG_RCD_W,
    parameter int ADDR_W = IMG_ADDR_W,
    parameter int KPT_W  = IMG_KPT_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [KPT_W-1:0]  kpt_num,
    input  logic              descriptor_request,
    output logic              descriptor_valid,
    output logic [ADDR_W-1:0] img_addr,
    input  logic [RCD_W-1:0]  img_dout_0,
    input  logic [RCD_W-1:0]  img_dout_1,
    input  logic [RCD_W-1:0]  img_dout_2,
    input  logic [RCD_W-1:0]  img_dout_3,
    output logic [RCD_W-1:0]  image_R_C_D_0,
    output logic [RCD_W-1:0]  image_R_C_D_1,
    output logic [RCD_W-1:0]  image_R_C_D_2,
    output logic [RCD_W-1:0]  image_R_C_D_3,
    output logic              feed_done,
    output logic              req_overrun
);

    feed_state_t       state;
    logic [ADDR_W:0]   grp_cnt;
    logic [ADDR_W:0]   grp_num;
    logic              req_armed;
    logic              cap_stb;
    logic [KPT_W-1:0]  kpt_groups;
    logic [RCD_W-1:0]  lane_in [4];

`ifdef IMG_PARTIAL_PAD_EN
    logic [1:0]        kpt_rem;
    assign kpt_groups = (kpt_num >> 2) + KPT_W'(kpt_num[1:0] != 2'd0);
`else
    assign kpt_groups = kpt_num >> 2;
`endif

    rd_lat_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_lat_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (start),
        .din   (state == ST_READ),
        .dout  (cap_stb)
    );

    // Lane data as it will be captured, with padding substituted in a partial last group
    always_comb begin
        lane_in[0] = img_dout_0;
        lane_in[1] = img_dout_1;
        lane_in[2] = img_dout_2;
        lane_in[3] = img_dout_3;
`ifdef IMG_PARTIAL_PAD_EN
        if (grp_cnt == grp_num - (ADDR_W+1)'(1)) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_is_pad(2'(i), kpt_rem)) begin
                    lane_in[i] = {RCD_W{1'b1}};
                end
            end
        end
`endif
    end

    // A held request only counts again once it has been seen low in WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            grp_cnt          <= '0;
            grp_num          <= '0;
            req_armed        <= 1'b0;
            descriptor_valid <= 1'b0;
            img_addr         <= '0;
            image_R_C_D_0    <= '0;
            image_R_C_D_1    <= '0;
            image_R_C_D_2    <= '0;
            image_R_C_D_3    <= '0;
            feed_done        <= 1'b0;
            req_overrun      <= 1'b0;
`ifdef IMG_PARTIAL_PAD_EN
            kpt_rem          <= '0;
`endif
        end else if (start) begin
            state            <= ST_WAIT;
            grp_cnt          <= '0;
            grp_num          <= (ADDR_W+1)'(kpt_groups);
            req_armed        <= 1'b1;
            descriptor_valid <= 1'b0;
            feed_done        <= 1'b0;
            req_overrun      <= 1'b0;
`ifdef IMG_PARTIAL_PAD_EN
            kpt_rem          <= kpt_num[1:0];
`endif
        end else begin
            descriptor_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    state <= ST_IDLE;
                end
                ST_WAIT: begin
                    if (descriptor_request && req_armed) begin
                        req_armed <= 1'b0;
                        if (grp_cnt < grp_num) begin
                            img_addr <= grp_cnt[ADDR_W-1:0];
                            state    <= ST_READ;
                        end else begin
                            req_overrun <= 1'b1;
                        end
                    end else if (!descriptor_request) begin
                        req_armed <= 1'b1;
                    end
                end
                ST_READ: begin
                    state <= ST_LAT;
                end
                ST_LAT: begin
                    if (cap_stb) begin
                        image_R_C_D_0    <= lane_in[0];
                        image_R_C_D_1    <= lane_in[1];
                        image_R_C_D_2    <= lane_in[2];
                        image_R_C_D_3    <= lane_in[3];
                        descriptor_valid <= 1'b1;
                        if ((grp_cnt + (ADDR_W+1)'(1)) == grp_num) begin
                            feed_done <= 1'b1;
                        end
                        state <= ST_VALID;
                    end
                end
                ST_VALID: begin
                    grp_cnt <= grp_cnt + (ADDR_W+1)'(1);
                    state   <= ST_WAIT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_img_descpt_feeder.sv
// Scoreboard bench for img_descpt_feeder; a second instance with RD_LAT=2 checks the longer latency.
module tb_img_descpt_feeder;
    import img_descpt_feeder_pkg::*;

    localparam int RCD_W  = IMG_RCD_W;
    localparam int ADDR_W = IMG_ADDR_W;
    localparam int KPT_W  = IMG_KPT_W;

    typedef logic [3:0][RCD_W-1:0] grp_t;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [KPT_W-1:0]  kpt_num;
    logic              descriptor_request;

    logic              descriptor_valid;
    logic [ADDR_W-1:0] img_addr;
    logic [RCD_W-1:0]  img_dout_0, img_dout_1, img_dout_2, img_dout_3;
    logic [RCD_W-1:0]  image_R_C_D_0, image_R_C_D_1, image_R_C_D_2, image_R_C_D_3;
    logic              feed_done;
    logic              req_overrun;

    logic              descriptor_valid2;
    logic [ADDR_W-1:0] img_addr2;
    logic [RCD_W-1:0]  img2_dout_0, img2_dout_1, img2_dout_2, img2_dout_3;
    logic [RCD_W-1:0]  image2_0, image2_1, image2_2, image2_3;
    logic              feed_done2;
    logic              req_overrun2;

    logic [ADDR_W-1:0] ra1, ra2a, ra2b;

    int   total;
    int   bad;
    grp_t sb[$];

    function automatic logic [RCD_W-1:0] mem_word(input int a, input int k);
        logic [RCD_W-1:0] w;
        w = '0;
        w[31:0] = 32'(a * 4 + k);
        w[RCD_W-1 -: 8] = 8'h5A;
        return w;
    endfunction

    img_descpt_feeder #(.RD_LAT(1)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .kpt_num            (kpt_num),
        .descriptor_request (descriptor_request),
        .descriptor_valid   (descriptor_valid),
        .img_addr           (img_addr),
        .img_dout_0         (img_dout_0),
        .img_dout_1         (img_dout_1),
        .img_dout_2         (img_dout_2),
        .img_dout_3         (img_dout_3),
        .image_R_C_D_0      (image_R_C_D_0),
        .image_R_C_D_1      (image_R_C_D_1),
        .image_R_C_D_2      (image_R_C_D_2),
        .image_R_C_D_3      (image_R_C_D_3),
        .feed_done          (feed_done),
        .req_overrun        (req_overrun)
    );

    img_descpt_feeder #(.RD_LAT(2)) dut2 (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .kpt_num            (kpt_num),
        .descriptor_request (descriptor_request),
        .descriptor_valid   (descriptor_valid2),
        .img_addr           (img_addr2),
        .img_dout_0         (img2_dout_0),
        .img_dout_1         (img2_dout_1),
        .img_dout_2         (img2_dout_2),
        .img_dout_3         (img2_dout_3),
        .image_R_C_D_0      (image2_0),
        .image_R_C_D_1      (image2_1),
        .image_R_C_D_2      (image2_2),
        .image_R_C_D_3      (image2_3),
        .feed_done          (feed_done2),
        .req_overrun        (req_overrun2)
    );

    always #5 clk = ~clk;

    // Image memory models: one and two cycle read latency
    always @(posedge clk) begin
        ra1  <= img_addr;
        ra2a <= img_addr2;
        ra2b <= ra2a;
    end

    assign img_dout_0  = mem_word(int'(ra1), 0);
    assign img_dout_1  = mem_word(int'(ra1), 1);
    assign img_dout_2  = mem_word(int'(ra1), 2);
    assign img_dout_3  = mem_word(int'(ra1), 3);
    assign img2_dout_0 = mem_word(int'(ra2b), 0);
    assign img2_dout_1 = mem_word(int'(ra2b), 1);
    assign img2_dout_2 = mem_word(int'(ra2b), 2);
    assign img2_dout_3 = mem_word(int'(ra2b), 3);

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every valid pulse must match the oldest expected group
    always @(negedge clk) begin
        if (rst_n && descriptor_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_valid: got valid with addr %0d, expected none", img_addr);
            end else begin
                grp_t g;
                g = sb.pop_front();
                checkOutput("lane0", 512'(image_R_C_D_0), 512'(g[0]));
                checkOutput("lane1", 512'(image_R_C_D_1), 512'(g[1]));
                checkOutput("lane2", 512'(image_R_C_D_2), 512'(g[2]));
                checkOutput("lane3", 512'(image_R_C_D_3), 512'(g[3]));
            end
        end
    end

    task automatic doStart(input int k);
        kpt_num = KPT_W'(k);
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    // One request handshake; called and returning at one time unit after a rising edge
    task automatic applyStimulus(input bit exp_valid, input int exp_addr, input int pad_from);
        grp_t g;
        int   n1, n2;
        for (int k = 0; k < 4; k++) begin
            g[k] = (k >= pad_from) ? PAD_WORD : mem_word(exp_addr, k);
        end
        if (exp_valid) sb.push_back(g);
        n1 = -1;
        n2 = -1;
        descriptor_request = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (descriptor_valid && n1 < 0) n1 = n;
            if (descriptor_valid2 && n2 < 0) n2 = n;
            if (n1 >= 0 && n2 >= 0) break;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        descriptor_request = 1'b0;
        @(posedge clk); #1;
        if (exp_valid) begin
            checkOutput("latency_lat1", 512'(n1), 512'(3));
            checkOutput("latency_lat2", 512'(n2), 512'(4));
            checkOutput("img_addr", 512'(img_addr), 512'(exp_addr));
            checkOutput("lat2_lane0", 512'(image2_0), 512'(g[0]));
            checkOutput("lat2_lane3", 512'(image2_3), 512'(g[3]));
        end else begin
            checkOutput("no_valid", 512'((n1 >= 0) || (n2 >= 0)), 512'(0));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int v1, v2;
        total = 0;
        bad   = 0;
        clk   = 1'b0;
        rst_n = 1'b0;
        start = 1'b0;
        kpt_num = '0;
        descriptor_request = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid", 512'(descriptor_valid), 512'(0));
        checkOutput("rst_addr", 512'(img_addr), 512'(0));
        checkOutput("rst_lane0", 512'(image_R_C_D_0), 512'(0));
        checkOutput("rst_feed_done", 512'(feed_done), 512'(0));
        checkOutput("rst_overrun", 512'(req_overrun), 512'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] kpt_num=16, four groups");
        doStart(16);
        for (int a = 0; a < 4; a++) begin
            applyStimulus(1'b1, a, 4);
            checkOutput("feed_done_16", 512'(feed_done), 512'(a == 3));
        end

        $display("[TB] kpt_num=8, overrun on third request");
        doStart(8);
        checkOutput("overrun_cleared", 512'(req_overrun), 512'(0));
        applyStimulus(1'b1, 0, 4);
        applyStimulus(1'b1, 1, 4);
        checkOutput("feed_done_8", 512'(feed_done), 512'(1));
        applyStimulus(1'b0, 0, 4);
        checkOutput("overrun_set", 512'(req_overrun), 512'(1));
        checkOutput("hold_lane0", 512'(image_R_C_D_0), 512'(mem_word(1, 0)));
        checkOutput("hold_lane3", 512'(image_R_C_D_3), 512'(mem_word(1, 3)));

        $display("[TB] kpt_num=10, partial last group");
        doStart(10);
        applyStimulus(1'b1, 0, 4);
        applyStimulus(1'b1, 1, 4);
`ifdef IMG_PARTIAL_PAD_EN
        checkOutput("feed_done_10a", 512'(feed_done), 512'(0));
        applyStimulus(1'b1, 2, 2);
        checkOutput("feed_done_10b", 512'(feed_done), 512'(1));
        checkOutput("overrun_10", 512'(req_overrun), 512'(0));
`else
        checkOutput("feed_done_10a", 512'(feed_done), 512'(1));
        applyStimulus(1'b0, 2, 4);
        checkOutput("overrun_10", 512'(req_overrun), 512'(1));
`endif

        $display("[TB] request held high");
        doStart(16);
        sb.push_back({mem_word(0, 3), mem_word(0, 2), mem_word(0, 1), mem_word(0, 0)});
        v1 = 0;
        v2 = 0;
        descriptor_request = 1'b1;
        for (int n = 0; n < 14; n++) begin
            @(negedge clk);
            if (descriptor_valid) v1++;
            if (descriptor_valid2) v2++;
            @(posedge clk); #1;
        end
        descriptor_request = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("held_pulses_lat1", 512'(v1), 512'(1));
        checkOutput("held_pulses_lat2", 512'(v2), 512'(1));
        applyStimulus(1'b1, 1, 4);

        $display("[TB] start during LAT aborts the read");
        descriptor_request = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1;
        descriptor_request = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        v1 = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (descriptor_valid || descriptor_valid2) v1++;
            @(posedge clk); #1;
        end
        checkOutput("abort_no_valid", 512'(v1), 512'(0));
        applyStimulus(1'b1, 0, 4);
        applyStimulus(1'b1, 1, 4);

        $display("[TB] async reset during READ");
        descriptor_request = 1'b1;
        @(posedge clk); #1;
        checkOutput("read_addr", 512'(img_addr), 512'(2));
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_addr", 512'(img_addr), 512'(0));
        checkOutput("arst_lane0", 512'(image_R_C_D_0), 512'(0));
        checkOutput("arst_lane3", 512'(image_R_C_D_3), 512'(0));
        checkOutput("arst_valid", 512'(descriptor_valid), 512'(0));
        checkOutput("arst_addr2", 512'(img_addr2), 512'(0));
        checkOutput("arst_lat2_lane0", 512'(image2_0), 512'(0));
        descriptor_request = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", 512'(sb.size()), 512'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
